// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file write-port arbiter.
// The register file uses the same DATA_WIDTH/ADDR_WIDTH/NUM_REGS.
package reg_wb_arbiter_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// 2-way round-robin grant, purely combinational; one-hot (or zero) grant.
// A lone valid always wins; on contention the port named by i_ptr wins.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);
    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Clears r1..r31 after reset, then round-robins two writeback ports onto the
// register-file write port; 1-cycle registered latency, ready=0 during clear.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = reg_wb_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_wb_arbiter_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  init_done
);
    localparam int                    NUM_REGS_L = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS_L - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_ptr;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_init_done;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  w_ptr_nxt;
    logic                  w_wen_nxt;
    logic [ADDR_WIDTH-1:0] w_waddr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic                  w_init_done_nxt;
    logic [1:0]            w_grant;
    logic                  w_rdy0;
    logic                  w_rdy1;

    rr_arb2 u_rr_arb2 (
        .i_valid ({req1_valid, req0_valid}),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign w_rdy0     = (r_state == ST_RUN) && w_grant[0];
    assign w_rdy1     = (r_state == ST_RUN) && w_grant[1];
    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_wen_nxt       = 1'b0;
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;
        w_init_done_nxt = r_init_done;
        case (r_state)
            ST_INIT: begin
                w_wen_nxt   = 1'b1;
                w_waddr_nxt = r_cnt;
                w_wdata_nxt = '0;
                // cnt stops advancing once RUN is entered, so it never wraps inside INIT
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt     = ST_RUN;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (w_rdy0) begin
                    w_waddr_nxt = req0_addr;
                    w_wdata_nxt = req0_data;
                    w_wen_nxt   = (req0_addr != '0);
                    w_ptr_nxt   = 1'b1;
                end else if (w_rdy1) begin
                    w_waddr_nxt = req1_addr;
                    w_wdata_nxt = req1_data;
                    w_wen_nxt   = (req1_addr != '0);
                    w_ptr_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= ADDR_WIDTH'(1);
            r_ptr       <= 1'b0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_wen       <= w_wen_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    assign wen       = r_wen;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign init_done = r_init_done;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized bench for reg_wb_arbiter against a cycle-level behavioural model.
// Also keeps a register-file array fed by wen/waddr/wdata for end-to-end checks.
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req0_valid = 1'b0;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr = '0;
    logic [DATA_WIDTH-1:0] req0_data = '0;
    logic                  req1_valid = 1'b0;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr = '0;
    logic [DATA_WIDTH-1:0] req1_data = '0;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  init_done;

    reg_wb_arbiter #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // register file fed by the arbiter's write port
    logic [DATA_WIDTH-1:0] rf [NUM_REGS];
    always @(posedge clk) if (wen === 1'b1) rf[waddr] <= wdata;

    // requesters must hold a pending request stable until it is accepted
    assert property (@(posedge clk) (req0_valid && !req0_ready) |=>
                     (req0_valid && $stable(req0_addr) && $stable(req0_data)))
        else $error("requester 0 changed a pending request");
    assert property (@(posedge clk) (req1_valid && !req1_ready) |=>
                     (req1_valid && $stable(req1_addr) && $stable(req1_data)))
        else $error("requester 1 changed a pending request");

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // requester stimulus state
    logic                  p_v [2];
    logic [ADDR_WIDTH-1:0] p_a [2];
    logic [DATA_WIDTH-1:0] p_d [2];
    bit                    keep = 0;   // re-issue the same request after acceptance

    // reference model: expected registered outputs and abstract arbiter state
    logic                  e_wen, e_done;
    logic [ADDR_WIDTH-1:0] e_waddr;
    logic [DATA_WIDTH-1:0] e_wdata;
    bit                    m_run;
    int                    m_clr;
    int                    m_fav;
    int                    n_grant [2];

    task automatic model_reset();
        e_wen = 0; e_waddr = '0; e_wdata = '0; e_done = 0;
        m_run = 0; m_clr = 1; m_fav = 0;
    endtask

    task automatic step(input logic r);
        int win;
        @(negedge clk);
        chk("wen", 32'(wen), 32'(e_wen));
        chk("waddr", 32'(waddr), 32'(e_waddr));
        chk("wdata", wdata, e_wdata);
        chk("init_done", 32'(init_done), 32'(e_done));
        rst = r;
        req0_valid = p_v[0]; req0_addr = p_a[0]; req0_data = p_d[0];
        req1_valid = p_v[1]; req1_addr = p_a[1]; req1_data = p_d[1];
        #1;
        win = -1;
        if (m_run) begin
            if (p_v[0] && p_v[1]) win = m_fav;
            else if (p_v[0])      win = 0;
            else if (p_v[1])      win = 1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(req1_ready), 32'(win == 1));
        if (r) begin
            model_reset();
        end else if (!m_run) begin
            e_wen = 1; e_waddr = ADDR_WIDTH'(m_clr); e_wdata = '0;
            if (m_clr == NUM_REGS - 1) begin
                m_run = 1; e_done = 1;
            end
            m_clr++;
        end else if (win >= 0) begin
            e_waddr = p_a[win]; e_wdata = p_d[win]; e_wen = (p_a[win] != '0);
            m_fav = 1 - win;
        end else begin
            e_wen = 0;
        end
        if (win >= 0) begin
            n_grant[win]++;
            if (!keep) p_v[win] = 0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_v[i] = 0; p_a[i] = '0; p_d[i] = '0; n_grant[i] = 0;
        end
        rf[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) rf[i] = $urandom;
        model_reset();

        rst = 1'b1;
        @(negedge clk);
        step(1'b1);
        step(1'b1);

        // clear sequence, with port 0 already waiting part-way through it
        steps(10);
        p_v[0] = 1; p_a[0] = 5'd5; p_d[0] = 32'hDEADBEEF;
        steps(24);
        chk("grant0_after_init", 32'(n_grant[0]), 32'd1);
        steps(2);

        // write to r0 is accepted and dropped; ptr still advances
        p_v[1] = 1; p_a[1] = '0; p_d[1] = 32'hFFFFFFFF;
        steps(3);
        for (int i = 0; i < NUM_REGS; i++)
            chk($sformatf("rf[%0d]", i), rf[i], (i == 5) ? 32'hDEADBEEF : 32'h0);

        p_v[0] = 1; p_a[0] = 5'd9;  p_d[0] = 32'h99;
        p_v[1] = 1; p_a[1] = 5'd10; p_d[1] = 32'hAA;
        steps(4);

        // sustained contention, with a reset pulse in the middle
        keep = 1;
        p_v[0] = 1; p_a[0] = 5'd1; p_d[0] = 32'h11;
        p_v[1] = 1; p_a[1] = 5'd2; p_d[1] = 32'h22;
        steps(8);
        step(1'b1);
        steps(40);
        keep = 0;
        steps(3);

        // randomized traffic with occasional resets of random length
        for (int c = 0; c < 1500; c++) begin
            logic r;
            for (int n = 0; n < 2; n++) begin
                if (!p_v[n] && $urandom_range(0, 2) == 0) begin
                    p_v[n] = 1;
                    p_a[n] = ADDR_WIDTH'($urandom_range(0, NUM_REGS - 1));
                    p_d[n] = $urandom;
                end
            end
            r = ($urandom_range(0, 199) == 0);
            step(r);
            if (r) begin
                int hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) step(1'b1);
            end
        end
        steps(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
